dtlb_refill_walker: RTL and testbench
=====================================

DTLB_REFILL_WALKER -- requirements
Module: dtlb_refill_walker

Interface
REQ-001 SHALL have parameter TLB_ENTRIES, default 32, number of DTLB entries; index width is 5.
REQ-002 SHALL have parameter PTE_W, default 32, Sv32 PTE width.
REQ-003 SHALL use one clock; reset is synchronous and active-high.
REQ-004 SHALL have the following ports, in this order:
- clk, input, 1: rising-edge clock.
- rst, input, 1: synchronous active-high reset.
- miss, input, 1: DTLB lookup miss, level-sampled.
- vpn, input, 20: faulting virtual page number, valid with miss.
- satp_ppn, input, 22: root page-table PPN.
- mem_req, output, 1: PTE read request.
- mem_addr, output, 34: physical PTE address.
- mem_rvalid, input, 1: read data valid.
- mem_rdata, input, 32: PTE returned.
- we, output, 1: DTLB write strobe.
- write_addr, output, 5: DTLB entry index.
- write_data, output, 52: entry {VPN[51:32], PPN[31:10], RSW[9:8], D, A, G, U, X, W, R, V[0]}.
- busy, output, 1: walk in progress.
- refill_done, output, 1: one-cycle pulse with we.
- page_fault, output, 1: one-cycle pulse on an illegal walk.

Function
REQ-005 SHALL implement states IDLE, L1_REQ, L1_WAIT, L0_REQ, L0_WAIT, WRITE, FAULT; all outputs are registered.
REQ-006 In IDLE with miss=1, SHALL latch vpn and satp_ppn and go to L1_REQ; mem_req asserts the next cycle (cycle 1).
REQ-007 L1 address SHALL be {satp_ppn, vpn[19:10], 2'b00}; L0 address SHALL be {pte.PPN, vpn[9:0], 2'b00}.
REQ-008 mem_req and mem_addr SHALL be held stable until mem_rvalid; mem_req drops the cycle after mem_rvalid; mem_rvalid outside a WAIT state is ignored.
REQ-009 A PTE SHALL be invalid if V=0, or if R=0 and W=1; an invalid PTE goes to FAULT.
REQ-010 A PTE SHALL be a leaf if R=1 or X=1; a non-leaf PTE at L1 goes to L0_REQ; a non-leaf PTE at L0 goes to FAULT.
REQ-011 On an L1 leaf (superpage), PPN[9:0] SHALL be 0, else FAULT; the written PPN[9:0] is replaced by vpn[9:0].
REQ-012 In WRITE, SHALL drive we=1 and refill_done=1 for exactly one cycle with write_data={vpn, pte[31:0]} and write_addr=current replacement pointer, then return to IDLE.
REQ-013 In FAULT, SHALL pulse page_fault for one cycle with no we, then return to IDLE.
REQ-014 The replacement pointer SHALL increment after each WRITE, wrap 31->0, and not change on FAULT.
REQ-015 busy SHALL be 1 in every state except IDLE; miss while busy SHALL be ignored (no queueing).
REQ-016 After returning to IDLE, a still-asserted miss SHALL start a new walk on the next cycle.
REQ-017 A hit/write latency SHALL be 2 cycles plus memory latency per level, plus 1 cycle.

Reset
REQ-018 rst SHALL force IDLE, mem_req=0, we=0, refill_done=0, page_fault=0, busy=0, mem_addr=0, write_addr=0, write_data=0, and pointer=0, including in mid-walk.
REQ-019 A mem_rvalid arriving after a mid-walk reset SHALL be ignored.

Configuration
REQ-020 With DTLB_WALK_CNT_EN defined, SHALL add 32-bit outputs walk_count and fault_count, incremented on WRITE and FAULT, wrapping, and cleared by rst.
REQ-021 Without DTLB_WALK_CNT_EN, these ports and counters SHALL be absent.

Structure
REQ-022 Package dtlb_pkg SHALL hold the entry bit-position constants (V..VPN_high), the state enum, the widths (VPN 20, PPN 22, index 5) and the PTE flag constants.
REQ-023 Sub-module dtlb_repl_ptr SHALL hold the round-robin 5-bit pointer with inputs clk, rst and advance, and output ptr.

Verification
REQ-024 satp_ppn=0x00100, vpn=0x12345, L1 rdata=0x00080001, L0 rdata=0x000400CF -> mem_addr 0x100120 then 0x200D14; we=1, write_addr=0, write_data={0x12345,0x000400CF}.
REQ-025 Same vpn, L1 rdata=0x1000000F -> single read; write_data={0x12345,0x100D140F}.
REQ-026 L1 rdata=0x00000000 -> page_fault pulse, no we; pointer unchanged; the next walk writes index 0.
REQ-027 L1 rdata=0x1000040F (misaligned superpage) -> page_fault; L0 non-leaf 0x00000001 -> page_fault.
REQ-028 33 successful refills -> write_addr 0..31 then 0; miss toggled during busy -> no extra walk.
REQ-029 rst asserted during L0_WAIT, then a late mem_rvalid -> outputs at reset values, no we, IDLE.

Source files
------------

// File: rtl/dtlb_pkg.sv
// Shared widths, DTLB entry bit positions, Sv32 PTE flags and walker states
// for the DTLB refill walker.
package dtlb_pkg;

    localparam int VPN_W    = 20;
    localparam int PPN_W    = 22;
    localparam int IDX_W    = 5;
    localparam int PTE_BITS = 32;
    localparam int PA_W     = 34;

    localparam int E_V      = 0;
    localparam int E_R      = 1;
    localparam int E_W      = 2;
    localparam int E_X      = 3;
    localparam int E_U      = 4;
    localparam int E_G      = 5;
    localparam int E_A      = 6;
    localparam int E_D      = 7;
    localparam int E_RSW_LO = 8;
    localparam int E_RSW_HI = 9;
    localparam int E_PPN_LO = 10;
    localparam int E_PPN_HI = 31;
    localparam int E_VPN_LO = 32;
    localparam int E_VPN_HI = 51;

    localparam logic [7:0] FLAG_V = 8'h01;
    localparam logic [7:0] FLAG_R = 8'h02;
    localparam logic [7:0] FLAG_W = 8'h04;
    localparam logic [7:0] FLAG_X = 8'h08;
    localparam logic [7:0] FLAG_U = 8'h10;
    localparam logic [7:0] FLAG_G = 8'h20;
    localparam logic [7:0] FLAG_A = 8'h40;
    localparam logic [7:0] FLAG_D = 8'h80;

    typedef enum logic [2:0] {
        IDLE,
        L1_REQ,
        L1_WAIT,
        L0_REQ,
        L0_WAIT,
        WRITE,
        FAULT
    } walk_state_t;

    // Write-only mappings are reserved encodings in Sv32.
    function automatic logic pte_invalid(input logic [PTE_BITS-1:0] pte);
        return ((pte[7:0] & FLAG_V) == 8'h00) ||
               ((pte[7:0] & (FLAG_R | FLAG_W)) == FLAG_W);
    endfunction

    function automatic logic pte_is_leaf(input logic [PTE_BITS-1:0] pte);
        return (pte[7:0] & (FLAG_R | FLAG_X)) != 8'h00;
    endfunction

endpackage

// File: rtl/dtlb_repl_ptr.sv
// Round-robin DTLB replacement pointer; advances once per completed refill.
module dtlb_repl_ptr
    import dtlb_pkg::*;
#(
    parameter int ENTRIES = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             advance,
    output logic [IDX_W-1:0] ptr
);

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
        end else if (advance) begin
            ptr <= (ptr == IDX_W'(ENTRIES - 1)) ? '0 : ptr + 1'b1;
        end
    end

endmodule

// File: rtl/dtlb_refill_walker.sv
// Two-level Sv32 page-table walker that refills the DTLB on a miss.
// Define DTLB_WALK_CNT_EN to add the walk_count / fault_count outputs.
module dtlb_refill_walker
    import dtlb_pkg::*;
#(
    parameter int TLB_ENTRIES = 32,
    parameter int PTE_W       = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   miss,
    input  logic [VPN_W-1:0]       vpn,
    input  logic [PPN_W-1:0]       satp_ppn,
    output logic                   mem_req,
    output logic [PA_W-1:0]        mem_addr,
    input  logic                   mem_rvalid,
    input  logic [PTE_W-1:0]       mem_rdata,
    output logic                   we,
    output logic [IDX_W-1:0]       write_addr,
    output logic [VPN_W+PTE_W-1:0] write_data,
    output logic                   busy,
    output logic                   refill_done,
    output logic                   page_fault
`ifdef DTLB_WALK_CNT_EN
    ,
    output logic [31:0]            walk_count,
    output logic [31:0]            fault_count
`endif
);

    walk_state_t      state;
    logic [VPN_W-1:0] vpn_q;
    logic [IDX_W-1:0] ptr;
    logic             advance;

    assign advance = (state == WRITE);

    dtlb_repl_ptr #(
        .ENTRIES (TLB_ENTRIES)
    ) u_repl_ptr (
        .clk     (clk),
        .rst     (rst),
        .advance (advance),
        .ptr     (ptr)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            vpn_q       <= '0;
            mem_req     <= 1'b0;
            mem_addr    <= '0;
            we          <= 1'b0;
            refill_done <= 1'b0;
            page_fault  <= 1'b0;
            busy        <= 1'b0;
            write_addr  <= '0;
            write_data  <= '0;
        end else begin
            we          <= 1'b0;
            refill_done <= 1'b0;
            page_fault  <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (miss) begin
                        vpn_q    <= vpn;
                        mem_addr <= {satp_ppn, vpn[VPN_W-1:10], 2'b00};
                        mem_req  <= 1'b1;
                        busy     <= 1'b1;
                        state    <= L1_REQ;
                    end
                end
                L1_REQ: state <= L1_WAIT;
                L1_WAIT: begin
                    if (mem_rvalid) begin
                        mem_req <= 1'b0;
                        if (pte_invalid(mem_rdata)) begin
                            page_fault <= 1'b1;
                            state      <= FAULT;
                        end else if (pte_is_leaf(mem_rdata)) begin
                            // A 4 MiB superpage must be aligned; its low PPN comes from the VPN.
                            if (mem_rdata[E_PPN_LO+9:E_PPN_LO] != '0) begin
                                page_fault <= 1'b1;
                                state      <= FAULT;
                            end else begin
                                write_data  <= {vpn_q, mem_rdata[E_PPN_HI:E_PPN_LO+10],
                                                vpn_q[9:0], mem_rdata[E_RSW_HI:E_V]};
                                write_addr  <= ptr;
                                we          <= 1'b1;
                                refill_done <= 1'b1;
                                state       <= WRITE;
                            end
                        end else begin
                            mem_addr <= {mem_rdata[E_PPN_HI:E_PPN_LO], vpn_q[9:0], 2'b00};
                            state    <= L0_REQ;
                        end
                    end
                end
                L0_REQ: begin
                    mem_req <= 1'b1;
                    state   <= L0_WAIT;
                end
                L0_WAIT: begin
                    if (mem_rvalid) begin
                        mem_req <= 1'b0;
                        if (pte_invalid(mem_rdata) || !pte_is_leaf(mem_rdata)) begin
                            page_fault <= 1'b1;
                            state      <= FAULT;
                        end else begin
                            write_data  <= {vpn_q, mem_rdata};
                            write_addr  <= ptr;
                            we          <= 1'b1;
                            refill_done <= 1'b1;
                            state       <= WRITE;
                        end
                    end
                end
                WRITE, FAULT: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef DTLB_WALK_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            walk_count  <= '0;
            fault_count <= '0;
        end else begin
            if (state == WRITE) walk_count  <= walk_count + 32'd1;
            if (state == FAULT) fault_count <= fault_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_dtlb_refill_walker.sv
// Self-checking bench for dtlb_refill_walker: directed cases plus randomized
// walks checked against a page-table-walk reference model.
module tb_dtlb_refill_walker;

    logic        clk = 1'b0;
    logic        rst;
    logic        miss;
    logic [19:0] vpn;
    logic [21:0] satp_ppn;
    logic        mem_req;
    logic [33:0] mem_addr;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        we;
    logic [4:0]  write_addr;
    logic [51:0] write_data;
    logic        busy;
    logic        refill_done;
    logic        page_fault;
`ifdef DTLB_WALK_CNT_EN
    logic [31:0] walk_count;
    logic [31:0] fault_count;
`endif

    int checks    = 0;
    int errors    = 0;
    int model_ptr = 0;
    int n_wr      = 0;
    int n_ft      = 0;

    dtlb_refill_walker dut (
        .clk         (clk),
        .rst         (rst),
        .miss        (miss),
        .vpn         (vpn),
        .satp_ppn    (satp_ppn),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_rvalid  (mem_rvalid),
        .mem_rdata   (mem_rdata),
        .we          (we),
        .write_addr  (write_addr),
        .write_data  (write_data),
        .busy        (busy),
        .refill_done (refill_done),
        .page_fault  (page_fault)
`ifdef DTLB_WALK_CNT_EN
        ,
        .walk_count  (walk_count),
        .fault_count (fault_count)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic bit pte_bad(input logic [31:0] p);
        return (p[0] == 1'b0) || (p[1] == 1'b0 && p[2] == 1'b1);
    endfunction

    function automatic bit pte_leaf(input logic [31:0] p);
        return p[1] || p[3];
    endfunction

    // Reference walk: read addresses, read count, fault outcome and DTLB entry.
    function automatic void model(input logic [21:0] satp, input logic [19:0] v,
                                  input logic [31:0] l1, input logic [31:0] l0,
                                  output int nr, output logic [33:0] a0,
                                  output logic [33:0] a1, output bit f,
                                  output logic [51:0] wd);
        longint unsigned p1 = l1;
        longint unsigned vv = v;
        longint unsigned sp = satp;
        a0 = 34'(sp * 4096 + (vv / 1024) * 4);
        a1 = 34'((p1 / 1024) * 4096 + (vv % 1024) * 4);
        nr = 1;
        f  = 1'b0;
        wd = '0;
        if (pte_bad(l1)) begin
            f = 1'b1;
        end else if (pte_leaf(l1)) begin
            if ((p1 / 1024) % 1024 != 0) f = 1'b1;
            else wd = {v, 32'(p1 + (vv % 1024) * 1024)};
        end else begin
            nr = 2;
            if (pte_bad(l0) || !pte_leaf(l0)) f = 1'b1;
            else wd = {v, l0};
        end
    endfunction

    task automatic serve(input logic [33:0] addr, input logic [31:0] data,
                         input bit last, input bit hold, output bit ok);
        int k = 0;
        ok = 1'b0;
        while (mem_req !== 1'b1 && k < 8) begin
            @(negedge clk);
            k++;
        end
        chk("req_seen", mem_req, 1);
        if (mem_req !== 1'b1) return;
        chk("req_addr", mem_addr, addr);
        repeat ($urandom_range(1, 3)) begin
            if (!hold) miss = 1'($urandom_range(0, 1));
            @(negedge clk);
            chk("req_hold", {mem_req, mem_addr}, {1'b1, addr});
        end
        mem_rvalid = 1'b1;
        mem_rdata  = data;
        if (last) miss = hold;
        @(negedge clk);
        mem_rvalid = 1'b0;
        mem_rdata  = $urandom;
        chk("req_drop", mem_req, 0);
        ok = 1'b1;
    endtask

    // Call at a falling edge with the walker idle; returns at an idle falling edge.
    task automatic run_walk(input logic [21:0] satp, input logic [19:0] v,
                            input logic [31:0] l1, input logic [31:0] l0,
                            input bit started, input bit hold);
        int          nr;
        logic [33:0] a0, a1;
        bit          f, ok;
        logic [51:0] wd;
        model(satp, v, l1, l0, nr, a0, a1, f, wd);
        if (!started) begin
            miss     = 1'b1;
            vpn      = v;
            satp_ppn = satp;
        end
        @(negedge clk);
        chk("start_req", {busy, mem_req}, 2'b11);
        if (!hold) miss = 1'b0;
        serve(a0, l1, nr == 1, hold, ok);
        if (!ok) return;
        if (nr == 2) begin
            chk("mid_quiet", {we, page_fault, busy}, 3'b001);
            serve(a1, l0, 1'b1, hold, ok);
            if (!ok) return;
        end
        chk("we", we, !f);
        chk("refill_done", refill_done, !f);
        chk("page_fault", page_fault, f);
        chk("busy_end", busy, 1);
        if (!f) begin
            chk("write_addr", write_addr, model_ptr);
            chk("write_data", write_data, wd);
            model_ptr = (model_ptr + 1) % 32;
            n_wr++;
        end else begin
            n_ft++;
        end
        @(negedge clk);
        chk("idle", {busy, we, refill_done, page_fault, mem_req}, 0);
        if (!hold) begin
            @(negedge clk);
            chk("no_extra", {busy, mem_req}, 0);
        end
    endtask

    initial begin
        int          nr;
        logic [33:0] a0, a1;
        bit          f, ok;
        logic [51:0] wd;
        logic [31:0] l1, l0;
        logic [19:0] v;
        logic [21:0] s;

        rst        = 1'b1;
        miss       = 1'b0;
        vpn        = '0;
        satp_ppn   = '0;
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
        repeat (3) @(negedge clk);
        chk("rst_ctrl", {mem_req, we, refill_done, page_fault, busy}, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_waddr", write_addr, 0);
        chk("rst_wdata", write_data, 0);
`ifdef DTLB_WALK_CNT_EN
        chk("rst_cnt", {walk_count, fault_count}, 0);
`endif
        rst = 1'b0;
        @(negedge clk);

        // Invalid root PTE faults and leaves the pointer at 0.
        run_walk(22'h00100, 20'h12345, 32'h00000000, 32'h00000000, 0, 0);
        run_walk(22'h00100, 20'h12345, 32'h00080001, 32'h000400CF, 0, 0);
        run_walk(22'h00100, 20'h12345, 32'h1000000F, 32'h00000000, 0, 0);
        run_walk(22'h00100, 20'h12345, 32'h1000040F, 32'h00000000, 0, 0);
        run_walk(22'h00100, 20'h12345, 32'h00080001, 32'h00000001, 0, 0);
        run_walk(22'h00100, 20'h12345, 32'h00080001, 32'h00000004, 0, 0);

        mem_rvalid = 1'b1;
        mem_rdata  = 32'h1000000F;
        @(negedge clk);
        mem_rvalid = 1'b0;
        @(negedge clk);
        chk("stray_rvalid", {busy, we, mem_req, page_fault}, 0);

        // miss held high across the end of a walk starts the next one at once.
        run_walk(22'h3ABCD, 20'hFEDCB, 32'h2000000B, 32'h0, 0, 1);
        run_walk(22'h3ABCD, 20'hFEDCB, 32'h2000000B, 32'h0, 1, 0);

        for (int i = 0; i < 33; i++) begin
            l1 = ($urandom & ~32'hE) | 32'h1;
            l0 = $urandom | 32'h3;
            run_walk(22'($urandom), 20'($urandom), l1, l0, 0, 0);
        end

        for (int i = 0; i < 24; i++) begin
            case ($urandom_range(0, 3))
                0:       l1 = ($urandom & ~32'hE) | 32'h1;
                1:       l1 = ($urandom & 32'hFFF003FF) | 32'h3;
                2:       l1 = $urandom;
                default: l1 = $urandom | 32'h403;
            endcase
            l0 = $urandom;
            run_walk(22'($urandom), 20'($urandom), l1, l0, 0, 0);
        end

        // Reset in L0_WAIT, then a late response must be ignored.
        v  = 20'h0ABCD;
        s  = 22'h01234;
        l1 = 32'h00555001;
        model(s, v, l1, 32'h0, nr, a0, a1, f, wd);
        miss     = 1'b1;
        vpn      = v;
        satp_ppn = s;
        @(negedge clk);
        serve(a0, l1, 1'b0, 1'b0, ok);
        miss = 1'b0;
        for (int k = 0; k < 8 && mem_req !== 1'b1; k++) @(negedge clk);
        chk("l0_req_before_rst", {mem_req, mem_addr}, {1'b1, a1});
        rst = 1'b1;
        @(negedge clk);
        rst        = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h000400CF;
        model_ptr  = 0;
        n_wr       = 0;
        n_ft       = 0;
        @(negedge clk);
        mem_rvalid = 1'b0;
        chk("rst_mid_ctrl", {mem_req, we, refill_done, page_fault, busy}, 0);
        chk("rst_mid_addr", mem_addr, 0);
        chk("rst_mid_wdata", {write_addr, write_data}, 0);
        @(negedge clk);
        chk("rst_mid_idle", {busy, we, mem_req}, 0);
        run_walk(22'h00100, 20'h12345, 32'h00080001, 32'h000400CF, 0, 0);

`ifdef DTLB_WALK_CNT_EN
        chk("walk_count", walk_count, n_wr);
        chk("fault_count", fault_count, n_ft);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
